cla_seq_adder: RTL
==================

// Module: cla_seq_adder
// PURPOSE
//  Multi-cycle wide adder that time-multiplexes one 4-bit CLA slice across WIDTH-bit operands.
//  Processes one nibble per cycle, LSB first, with a registered carry between nibbles.
//  Sits between an operand producer and a result consumer.
//  Uses valid/ready handshakes on both sides and holds one operation in flight.
// PARAMETERS
//  WIDTH    16   operand/result width; multiple of 4, >= 4
//  NIBBLES  WIDTH/4   derived localparam; number of CLA passes per operation
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      reset, asynchronous, active-high
//  in_valid   in   1      operands a, b and cin are valid
//  in_ready   out  1      block can accept an operation (IDLE only)
//  a          in   WIDTH  augend
//  b          in   WIDTH  addend
//  cin        in   1      carry in
//  sub        in   1      subtract request (used only with CLA_SEQ_SUB_EN)
//  out_valid  out  1      sum and cout are valid
//  out_ready  in   1      consumer accepts the result
//  sum        out  WIDTH  registered result
//  cout       out  1      registered carry out of the MSB nibble
//  busy       out  1      high in RUN or DONE
// BEHAVIOUR
//  - Reset: state=IDLE, nibble index=0, carry=0, sum=0, cout=0, out_valid=0, busy=0; in_ready=1 after reset releases.
//  - Operand capture: clock edge in IDLE with in_valid=1 latches a, b and cin into internal registers, sets idx=0 and moves to RUN.
//  - RUN: each cycle the CLA slice gets a[4*idx+:4], b[4*idx+:4] and the carry register.
//      Its sum nibble is written to sum[4*idx+:4] and the carry register takes the slice carry out.
//      idx increments; the edge that processes idx==NIBBLES-1 moves to DONE, sets cout and clears idx.
//  - DONE: out_valid=1. sum and cout stay stable until out_ready=1, then the block returns to IDLE.
//  - Latency: if the operation is accepted at edge k, out_valid rises after edge k+NIBBLES. No overlap between operations.
//  - in_ready=1 only in IDLE. in_valid in RUN/DONE is ignored; the producer must hold it.
//  - Simultaneous events: out_ready in DONE and a pending in_valid -> the result retires this edge and the new operation is accepted the next edge.
//  - Outputs: sum and cout are not cleared on leaving DONE. The previous result is visible but qualified only by out_valid.
//  - Arithmetic: modulo 2^WIDTH, with cout = bit WIDTH of a+b+cin.
//  - WIDTH=4: a single RUN cycle.
//  - Reset mid-operation: abort immediately to reset values; the partial sum is discarded.
// CONFIGURATION
//  CLA_SEQ_SUB_EN defined:
//    - sub=1 at capture stores ~b and forces the initial carry to 1, giving a-b.
//    - cin is ignored when sub=1. cout=1 means no borrow.
//  CLA_SEQ_SUB_EN undefined:
//    - The sub port stays in the port list but is unused; the block only adds.
// STRUCTURE
//  Shared package cla_seq_pkg:
//    - NIBBLE_W=4.
//    - State encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2; 2'd3 is illegal and recovers to IDLE.
//  Sub-module cla_nibble: combinational 4-bit carry-lookahead slice.
//    - Ports a[3:0], b[3:0], cin; outputs sum[3:0], cout.
//    - Gate-level generate/propagate logic.
//    - Instantiated once and driven by the idx mux.
//  Top level holds the FSM, idx counter, carry register, operand registers and result register.
// TESTING
//  1. WIDTH=16, a=16'h1234, b=16'h4321, cin=0 -> out_valid 4 cycles after accept; sum=16'h5555, cout=0.
//  2. a=16'hFFFF, b=16'h0001, cin=0 -> carry ripples through all nibbles; sum=16'h0000, cout=1.
//  3. Hold out_ready=0 for 5 cycles after out_valid -> sum, cout and out_valid stable; in_ready=0; new in_valid not taken until retire+1.
//  4. Assert rst on the 2nd RUN cycle of a=16'hAAAA, b=16'h5555 -> next cycle IDLE, sum=0, out_valid=0, in_ready=1.
//  5. With CLA_SEQ_SUB_EN: sub=1, a=16'h0005, b=16'h0007 -> sum=16'hFFFE, cout=0; a=16'h0007, b=16'h0005 -> sum=16'h0002, cout=1.
//  6. 1000 random back-to-back operations with random out_ready gaps, WIDTH=16 and WIDTH=4 -> match the {cout,sum} model; no result dropped or duplicated.

Source files
------------

// File: rtl/cla_seq_pkg.sv
// Shared constants for the sequential CLA adder: slice width and FSM state encodings.
package cla_seq_pkg;

   localparam int NIBBLE_W = 4;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/cla_nibble.sv
// Combinational 4-bit carry-lookahead slice built from generate/propagate terms.
module cla_nibble (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);

   logic [3:0] g;
   logic [3:0] p;
   logic [3:0] c;

   assign g = a & b;
   assign p = a ^ b;

   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & cin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
   assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & cin);

   assign sum = p ^ c;

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle WIDTH-bit adder reusing one 4-bit CLA slice, LSB nibble first.
// Define CLA_SEQ_SUB_EN to enable subtraction via the sub input.
module cla_seq_adder
   import cla_seq_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);

   localparam int NIBBLES = WIDTH / NIBBLE_W;
   localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   logic [1:0]          state;
   logic [IDX_W-1:0]    idx;
   logic                carry;
   logic [WIDTH-1:0]    a_q;
   logic [WIDTH-1:0]    b_q;
   logic [WIDTH-1:0]    b_in;
   logic                carry_in;
   logic [NIBBLE_W-1:0] nib_a;
   logic [NIBBLE_W-1:0] nib_b;
   logic [NIBBLE_W-1:0] nib_sum;
   logic                nib_cout;

`ifdef CLA_SEQ_SUB_EN
   // a - b as a + ~b + 1; cin is ignored for subtraction
   assign b_in     = sub ? ~b : b;
   assign carry_in = sub ? 1'b1 : cin;
`else
   logic unused_sub;
   assign unused_sub = sub;
   assign b_in       = b;
   assign carry_in   = cin;
`endif

   assign nib_a = a_q[NIBBLE_W*idx +: NIBBLE_W];
   assign nib_b = b_q[NIBBLE_W*idx +: NIBBLE_W];

   cla_nibble u_slice (
      .a    (nib_a),
      .b    (nib_b),
      .cin  (carry),
      .sum  (nib_sum),
      .cout (nib_cout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         idx   <= '0;
         carry <= 1'b0;
         a_q   <= '0;
         b_q   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q   <= a;
                  b_q   <= b_in;
                  carry <= carry_in;
                  idx   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               sum[NIBBLE_W*idx +: NIBBLE_W] <= nib_sum;
               carry <= nib_cout;
               if (idx == LAST_IDX) begin
                  idx   <= '0;
                  cout  <= nib_cout;
                  state <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state == RUN) || (state == DONE);

endmodule
